// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: groups the fetch, data and memory-bus signals of bus_arbiter.
// Ports: i_* are driven towards the arbiter, o_* are driven by it.
// Modports: slave = arbiter view, master = requesters + memory slave view.
interface bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Fetch side
  logic                  i_if_req;
  logic [ADDR_W-1:0]     i_if_addr;
  logic                  o_if_ack;
  logic [DATA_W-1:0]     o_if_rdata;
  // Data side
  logic                  i_mem_req;
  logic                  i_mem_we;
  logic [DATA_W/8-1:0]   i_mem_sel;
  logic [ADDR_W-1:0]     i_mem_addr;
  logic [DATA_W-1:0]     i_mem_wdata;
  logic                  o_mem_ack;
  logic [DATA_W-1:0]     o_mem_rdata;
  // Shared memory bus
  logic                  o_bus_req;
  logic                  o_bus_we;
  logic [DATA_W/8-1:0]   o_bus_sel;
  logic [ADDR_W-1:0]     o_bus_addr;
  logic [DATA_W-1:0]     o_bus_wdata;
  logic                  i_bus_ack;
  logic [DATA_W-1:0]     i_bus_rdata;
  // Status
  logic                  o_stall_if;
  logic                  o_stall_mem;
  logic                  o_err;

  modport slave (
    input  i_if_req, i_if_addr,
    input  i_mem_req, i_mem_we, i_mem_sel, i_mem_addr, i_mem_wdata,
    input  i_bus_ack, i_bus_rdata,
    output o_if_ack, o_if_rdata, o_mem_ack, o_mem_rdata,
    output o_bus_req, o_bus_we, o_bus_sel, o_bus_addr, o_bus_wdata,
    output o_stall_if, o_stall_mem, o_err
  );

  modport master (
    output i_if_req, i_if_addr,
    output i_mem_req, i_mem_we, i_mem_sel, i_mem_addr, i_mem_wdata,
    output i_bus_ack, i_bus_rdata,
    input  o_if_ack, o_if_rdata, o_mem_ack, o_mem_rdata,
    input  o_bus_req, o_bus_we, o_bus_sel, o_bus_addr, o_bus_wdata,
    input  o_stall_if, o_stall_mem, o_err
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one single-ported memory bus between fetch (IF) and data (MEM) requesters.
// Ports: clk, rst (async active-low), bus (bus_arbiter_if.slave). Latency: req -> o_bus_req 1 cycle, acks combinational.
// Backpressure: a requester stalls until its ack; a silent slave is aborted after TIMEOUT_CYC cycles.
module bus_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic         clk,
  input  logic         rst,
  bus_arbiter_if.slave bus
);
  localparam int SEL_W = DATA_W / 8;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);
  localparam int TC_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT_IF = 2'd1, GNT_MEM = 2'd2} state_t;

  state_t              state_q, state_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [SEL_W-1:0]    bus_sel_q, bus_sel_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [SC_W-1:0]     starve_cnt_q, starve_cnt_d;
  logic [TC_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic                err_q, err_d;

  logic gnt_if, gnt_mem, in_gnt, tmo_hit, done, starved, pick_if, pick_mem;

  always_comb begin
    gnt_if   = (state_q == GNT_IF);
    gnt_mem  = (state_q == GNT_MEM);
    in_gnt   = gnt_if | gnt_mem;
    // An ack arriving in the timeout cycle wins: it is a normal completion.
    tmo_hit  = in_gnt & ~bus.i_bus_ack & (tmo_cnt_q == TC_W'(TIMEOUT_CYC));
    done     = in_gnt & (bus.i_bus_ack | tmo_hit);
    starved  = (starve_cnt_q == SC_W'(STARVE_MAX)) & bus.i_if_req;

    // In an ack cycle only the other requester may take the bus back-to-back.
    pick_if  = 1'b0;
    pick_mem = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_mem_req && !starved) pick_mem = 1'b1;
        else if (bus.i_if_req)         pick_if  = 1'b1;
      end
      GNT_IF:  pick_mem = done & bus.i_mem_req;
      GNT_MEM: pick_if  = done & bus.i_if_req;
      default: ;
    endcase

    state_d      = state_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_sel_d    = bus_sel_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    starve_cnt_d = starve_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    err_d        = err_q | tmo_hit;

    if (in_gnt && !done) tmo_cnt_d = tmo_cnt_q + TC_W'(1);

    if (done) begin
      state_d     = IDLE;
      bus_req_d   = 1'b0;
      bus_we_d    = 1'b0;
      bus_sel_d   = '0;
      bus_addr_d  = '0;
      bus_wdata_d = '0;
      tmo_cnt_d   = '0;
    end

    if (state_q == IDLE && !bus.i_if_req) starve_cnt_d = '0;

    if (pick_mem) begin
      state_d     = GNT_MEM;
      bus_req_d   = 1'b1;
      bus_we_d    = bus.i_mem_we;
      bus_sel_d   = bus.i_mem_sel;
      bus_addr_d  = bus.i_mem_addr;
      bus_wdata_d = bus.i_mem_wdata;
      tmo_cnt_d   = '0;
      if (bus.i_if_req && starve_cnt_q != SC_W'(STARVE_MAX))
        starve_cnt_d = starve_cnt_q + SC_W'(1);
    end else if (pick_if) begin
      state_d      = GNT_IF;
      bus_req_d    = 1'b1;
      bus_we_d     = 1'b0;
      bus_sel_d    = '1;
      bus_addr_d   = bus.i_if_addr;
      bus_wdata_d  = '0;
      tmo_cnt_d    = '0;
      starve_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_sel_q    <= '0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      starve_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_sel_q    <= bus_sel_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      starve_cnt_q <= starve_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      err_q        <= err_d;
    end
  end

  logic if_ack, mem_ack;
  assign if_ack  = gnt_if  & (bus.i_bus_ack | tmo_hit);
  assign mem_ack = gnt_mem & (bus.i_bus_ack | tmo_hit);

  assign bus.o_if_ack    = if_ack;
  assign bus.o_mem_ack   = mem_ack;
  // Aborted cycles return zero data: rdata only passes on a real slave ack.
  assign bus.o_if_rdata  = (gnt_if  & bus.i_bus_ack) ? bus.i_bus_rdata : '0;
  assign bus.o_mem_rdata = (gnt_mem & bus.i_bus_ack) ? bus.i_bus_rdata : '0;
  assign bus.o_bus_req   = bus_req_q;
  assign bus.o_bus_we    = bus_we_q;
  assign bus.o_bus_sel   = bus_sel_q;
  assign bus.o_bus_addr  = bus_addr_q;
  assign bus.o_bus_wdata = bus_wdata_q;
  assign bus.o_stall_if  = bus.i_if_req  & ~if_ack;
  assign bus.o_stall_mem = bus.i_mem_req & ~mem_ack;
  // The flag shows in the abort cycle itself and stays set afterwards.
  assign bus.o_err       = err_q | tmo_hit;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed self-checking bench for bus_arbiter.
// Stimulus is driven on the falling edge, outputs are sampled 1 time unit later.
// Each scenario task holds its own comparisons against hand-computed values.
module tb_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif ();

  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT_CYC(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic idle_inputs();
    bif.i_if_req = 0; bif.i_if_addr = 0;
    bif.i_mem_req = 0; bif.i_mem_we = 0; bif.i_mem_sel = 0; bif.i_mem_addr = 0; bif.i_mem_wdata = 0;
    bif.i_bus_ack = 0; bif.i_bus_rdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if (bif.o_bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_bus_req: got %b expected 0", bif.o_bus_req); end
    n_chk++; if ({bif.o_bus_we, bif.o_bus_sel, bif.o_bus_addr, bif.o_bus_wdata} !== 69'd0) begin n_fail++; $display("FAIL reset_bus_fields: got we=%b sel=%h addr=%h wdata=%h expected all 0", bif.o_bus_we, bif.o_bus_sel, bif.o_bus_addr, bif.o_bus_wdata); end
    n_chk++; if ({bif.o_err, bif.o_if_ack, bif.o_mem_ack, bif.o_stall_if, bif.o_stall_mem} !== 5'b0) begin n_fail++; $display("FAIL reset_status: got err/ifack/memack/stif/stmem=%b expected 00000", {bif.o_err, bif.o_if_ack, bif.o_mem_ack, bif.o_stall_if, bif.o_stall_mem}); end
    @(negedge clk); rst = 1;
  endtask

  task automatic test_fetch();
    @(negedge clk); bif.i_if_req = 1; bif.i_if_addr = 32'h100;
    #1;
    n_chk++; if (bif.o_bus_req !== 1'b0) begin n_fail++; $display("FAIL fetch_no_zero_latency: got %b expected 0", bif.o_bus_req); end
    n_chk++; if (bif.o_stall_if !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_initial: got %b expected 1", bif.o_stall_if); end
    @(negedge clk); #1;
    n_chk++; if (bif.o_bus_req !== 1'b1 || bif.o_bus_addr !== 32'h100 || bif.o_bus_sel !== 4'hF || bif.o_bus_we !== 1'b0 || bif.o_bus_wdata !== 32'h0)
      begin n_fail++; $display("FAIL fetch_grant: got req=%b addr=%h sel=%h we=%b wdata=%h expected 1/100/f/0/0", bif.o_bus_req, bif.o_bus_addr, bif.o_bus_sel, bif.o_bus_we, bif.o_bus_wdata); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      n_chk++; if (bif.o_stall_if !== 1'b1 || bif.o_if_ack !== 1'b0) begin n_fail++; $display("FAIL fetch_wait%0d: got stall=%b ack=%b expected 1/0", i, bif.o_stall_if, bif.o_if_ack); end
    end
    @(negedge clk); bif.i_bus_ack = 1; bif.i_bus_rdata = 32'h24010001;
    #1;
    n_chk++; if (bif.o_if_ack !== 1'b1 || bif.o_if_rdata !== 32'h24010001) begin n_fail++; $display("FAIL fetch_ack: got ack=%b rdata=%h expected 1/24010001", bif.o_if_ack, bif.o_if_rdata); end
    n_chk++; if (bif.o_stall_if !== 1'b0 || bif.o_mem_ack !== 1'b0) begin n_fail++; $display("FAIL fetch_ack_side: got stall_if=%b mem_ack=%b expected 0/0", bif.o_stall_if, bif.o_mem_ack); end
    @(negedge clk); idle_inputs();
    #1;
    n_chk++; if (bif.o_bus_req !== 1'b0 || bif.o_bus_addr !== 32'h0) begin n_fail++; $display("FAIL fetch_release: got req=%b addr=%h expected 0/0", bif.o_bus_req, bif.o_bus_addr); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bif.i_if_req = 1; bif.i_if_addr = 32'h104;
    bif.i_mem_req = 1; bif.i_mem_we = 0; bif.i_mem_sel = 4'hF; bif.i_mem_addr = 32'h300;
    @(negedge clk); #1;
    n_chk++; if (bif.o_bus_req !== 1'b1 || bif.o_bus_addr !== 32'h300) begin n_fail++; $display("FAIL b2b_mem_first: got req=%b addr=%h expected 1/300", bif.o_bus_req, bif.o_bus_addr); end
    bif.i_bus_ack = 1; bif.i_bus_rdata = 32'h11;
    #1;
    n_chk++; if (bif.o_mem_ack !== 1'b1 || bif.o_if_ack !== 1'b0 || bif.o_mem_rdata !== 32'h11 || bif.o_if_rdata !== 32'h0)
      begin n_fail++; $display("FAIL b2b_mem_ack: got mem_ack=%b if_ack=%b mem_rdata=%h if_rdata=%h expected 1/0/11/0", bif.o_mem_ack, bif.o_if_ack, bif.o_mem_rdata, bif.o_if_rdata); end
    @(negedge clk); bif.i_mem_req = 0; bif.i_bus_rdata = 32'h22;
    #1;
    n_chk++; if (bif.o_bus_req !== 1'b1 || bif.o_bus_addr !== 32'h104 || bif.o_bus_sel !== 4'hF) begin n_fail++; $display("FAIL b2b_if_follow: got req=%b addr=%h sel=%h expected 1/104/f", bif.o_bus_req, bif.o_bus_addr, bif.o_bus_sel); end
    n_chk++; if (bif.o_if_ack !== 1'b1 || bif.o_if_rdata !== 32'h22) begin n_fail++; $display("FAIL b2b_if_ack: got ack=%b rdata=%h expected 1/22", bif.o_if_ack, bif.o_if_rdata); end
    @(negedge clk); idle_inputs();
    #1;
    n_chk++; if (bif.o_bus_req !== 1'b0) begin n_fail++; $display("FAIL b2b_release: got %b expected 0", bif.o_bus_req); end
  endtask

  // The fetch unit withdraws its unserved request during each data grant so that
  // every data grant starts from IDLE; this lets the starvation counter climb.
  task automatic test_starvation();
    logic [31:0] exp_addr;
    bif.i_mem_we = 0; bif.i_mem_sel = 4'hF; bif.i_mem_addr = 32'h400; bif.i_if_addr = 32'h108;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); bif.i_mem_req = 1; bif.i_if_req = 1; bif.i_bus_ack = 0;
      #1;
      n_chk++; if (bif.o_bus_req !== 1'b0) begin n_fail++; $display("FAIL starve_idle%0d: got req=%b expected 0", k, bif.o_bus_req); end
      @(negedge clk); #1;
      exp_addr = (k < 4) ? 32'h400 : 32'h108;
      n_chk++; if (bif.o_bus_req !== 1'b1 || bif.o_bus_addr !== exp_addr) begin n_fail++; $display("FAIL starve_grant%0d: got req=%b addr=%h expected 1/%h", k, bif.o_bus_req, bif.o_bus_addr, exp_addr); end
      if (k < 4) bif.i_if_req = 0;
      bif.i_bus_ack = 1; bif.i_bus_rdata = k;
      #1;
      if (k < 4) begin
        n_chk++; if (bif.o_mem_ack !== 1'b1) begin n_fail++; $display("FAIL starve_mem_ack%0d: got %b expected 1", k, bif.o_mem_ack); end
      end else begin
        n_chk++; if (bif.o_if_ack !== 1'b1 || bif.o_if_rdata !== 32'd4) begin n_fail++; $display("FAIL starve_if_ack: got ack=%b rdata=%h expected 1/4", bif.o_if_ack, bif.o_if_rdata); end
      end
    end
    @(negedge clk); bif.i_if_req = 0; bif.i_bus_rdata = 32'h77;
    #1;
    n_chk++; if (bif.o_bus_req !== 1'b1 || bif.o_bus_addr !== 32'h400 || bif.o_mem_ack !== 1'b1) begin n_fail++; $display("FAIL starve_mem_again: got req=%b addr=%h ack=%b expected 1/400/1", bif.o_bus_req, bif.o_bus_addr, bif.o_mem_ack); end
    @(negedge clk); idle_inputs();
    #1;
    n_chk++; if (bif.o_bus_req !== 1'b0) begin n_fail++; $display("FAIL starve_release: got %b expected 0", bif.o_bus_req); end
  endtask

  task automatic test_write();
    int acks = 0;
    int bad  = 0;
    @(negedge clk);
    bif.i_mem_req = 1; bif.i_mem_we = 1; bif.i_mem_sel = 4'b0011; bif.i_mem_addr = 32'h2000; bif.i_mem_wdata = 32'hDEADBEEF;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bif.i_bus_ack = (c == 5);
      if (c == 6) bif.i_mem_req = 0;
      #1;
      if (c <= 5 && (bif.o_bus_req !== 1'b1 || bif.o_bus_we !== 1'b1 || bif.o_bus_sel !== 4'b0011 || bif.o_bus_addr !== 32'h2000 || bif.o_bus_wdata !== 32'hDEADBEEF)) bad++;
      if (bif.o_mem_ack === 1'b1) acks++;
      if (c < 5) begin
        n_chk++; if (bif.o_stall_mem !== 1'b1) begin n_fail++; $display("FAIL write_stall%0d: got %b expected 1", c, bif.o_stall_mem); end
      end
    end
    n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL write_fields_stable: got %0d bad cycles expected 0", bad); end
    n_chk++; if (acks !== 1) begin n_fail++; $display("FAIL write_ack_pulses: got %0d expected 1", acks); end
    n_chk++; if (bif.o_bus_req !== 1'b0 || bif.o_bus_we !== 1'b0) begin n_fail++; $display("FAIL write_release: got req=%b we=%b expected 0/0", bif.o_bus_req, bif.o_bus_we); end
    idle_inputs();
  endtask

  task automatic test_timeout();
    int early = 0;
    @(negedge clk);
    bif.i_mem_req = 1; bif.i_mem_we = 0; bif.i_mem_sel = 4'hF; bif.i_mem_addr = 32'h3000;
    bif.i_bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk); #1;
    n_chk++; if (bif.o_bus_req !== 1'b1) begin n_fail++; $display("FAIL tmo_grant: got %b expected 1", bif.o_bus_req); end
    for (int c = 1; c < 255; c++) begin
      @(negedge clk); #1;
      if (bif.o_mem_ack === 1'b1) early++;
    end
    n_chk++; if (early !== 0 || bif.o_err !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got early_acks=%0d err=%b expected 0/0", early, bif.o_err); end
    @(negedge clk); #1;
    n_chk++; if (bif.o_mem_ack !== 1'b1 || bif.o_mem_rdata !== 32'h0 || bif.o_err !== 1'b1) begin n_fail++; $display("FAIL tmo_abort: got ack=%b rdata=%h err=%b expected 1/0/1", bif.o_mem_ack, bif.o_mem_rdata, bif.o_err); end
    @(negedge clk); bif.i_mem_req = 0;
    #1;
    n_chk++; if (bif.o_bus_req !== 1'b0 || bif.o_err !== 1'b1) begin n_fail++; $display("FAIL tmo_after: got req=%b err=%b expected 0/1", bif.o_bus_req, bif.o_err); end
    @(negedge clk); bif.i_mem_req = 1; bif.i_mem_addr = 32'h3004;
    @(negedge clk); bif.i_bus_ack = 1; bif.i_bus_rdata = 32'h55;
    #1;
    n_chk++; if (bif.o_bus_addr !== 32'h3004 || bif.o_mem_ack !== 1'b1 || bif.o_mem_rdata !== 32'h55 || bif.o_err !== 1'b1)
      begin n_fail++; $display("FAIL tmo_next_req: got addr=%h ack=%b rdata=%h err=%b expected 3004/1/55/1", bif.o_bus_addr, bif.o_mem_ack, bif.o_mem_rdata, bif.o_err); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_reset_mid_grant();
    @(negedge clk); bif.i_if_req = 1; bif.i_if_addr = 32'h500;
    @(negedge clk); #1;
    n_chk++; if (bif.o_bus_req !== 1'b1) begin n_fail++; $display("FAIL rst_pre_grant: got %b expected 1", bif.o_bus_req); end
    #2; rst = 0; bif.i_bus_ack = 1; bif.i_bus_rdata = 32'hABCD;
    #1;
    n_chk++; if (bif.o_bus_req !== 1'b0 || bif.o_bus_addr !== 32'h0 || bif.o_bus_sel !== 4'h0) begin n_fail++; $display("FAIL rst_async_drop: got req=%b addr=%h sel=%h expected 0/0/0", bif.o_bus_req, bif.o_bus_addr, bif.o_bus_sel); end
    n_chk++; if (bif.o_if_ack !== 1'b0 || bif.o_if_rdata !== 32'h0 || bif.o_err !== 1'b0) begin n_fail++; $display("FAIL rst_no_ack: got ack=%b rdata=%h err=%b expected 0/0/0", bif.o_if_ack, bif.o_if_rdata, bif.o_err); end
    @(negedge clk); bif.i_bus_ack = 0; rst = 1;
    @(negedge clk); #1;
    n_chk++; if (bif.o_bus_req !== 1'b1 || bif.o_bus_addr !== 32'h500) begin n_fail++; $display("FAIL rst_regrant: got req=%b addr=%h expected 1/500", bif.o_bus_req, bif.o_bus_addr); end
    bif.i_bus_ack = 1; bif.i_bus_rdata = 32'h600D;
    #1;
    n_chk++; if (bif.o_if_ack !== 1'b1 || bif.o_if_rdata !== 32'h600D) begin n_fail++; $display("FAIL rst_regrant_ack: got ack=%b rdata=%h expected 1/600d", bif.o_if_ack, bif.o_if_rdata); end
    @(negedge clk); idle_inputs();
    #1;
    n_chk++; if (bif.o_bus_req !== 1'b0) begin n_fail++; $display("FAIL rst_release: got %b expected 0", bif.o_bus_req); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_back_to_back();
    test_starvation();
    test_write();
    test_timeout();
    test_reset_mid_grant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
